closest_hit_select: RTL and testbench
=====================================

// Module: closest_hit_select
// PURPOSE
//  Downstream of the primitive (per-box AABB) stage. Collects the BOX_COUNT per-core slab-test
//  results for one tagged ray; cores finish on independent cycles.
//  Scans the results sequentially and selects the nearest hit (smallest non-negative tnear).
//  Delivers one closest-hit record per ray to the shading/traversal stage over a valid/ready handshake.
// PARAMETERS
//  WIDTH         16      tnear width, signed Q3.12
//  BOX_COUNT     4       number of AABB cores/lanes (>=2)
//  TAG_W         8       ray tag width
//  MAX           16'h7FFF  tnear reported on miss
//  TIMEOUT_CYC   64      collect watchdog limit (used only with CLOSEST_HIT_TIMEOUT_EN)
// PORTS
//  clk          in   1                 clock
//  reset        in   1                 synchronous, active-high
//  start        in   1                 1-cycle pulse: new ray issued to AABB cores
//  ray_tag_in   in   TAG_W             tag of ray, sampled with start
//  busy         out  1                 1 whenever state != IDLE
//  core_valid   in   BOX_COUNT         per-lane result strobe
//  core_hit     in   BOX_COUNT         per-lane hit flag
//  core_tnear   in   BOX_COUNT*WIDTH   per-lane entry distance, lane i at [i*WIDTH +: WIDTH]
//  out_valid    out  1                 result available
//  out_ready    in   1                 consumer accepts
//  out_hit      out  1                 any lane hit
//  out_index    out  $clog2(BOX_COUNT) winning lane
//  out_tnear    out  WIDTH             winning tnear (clamped), MAX on miss
//  out_tag      out  TAG_W             tag of the ray
//  out_timeout  out  1                 collect aborted by watchdog (0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE; busy, out_valid, out_hit, out_index, out_timeout = 0; out_tnear=MAX;
//   out_tag=0; lane mask cleared. Reset mid-operation aborts the ray; nothing is emitted.
//  FSM IDLE->COLLECT->SCAN->OUT->IDLE.
//  IDLE: start=1 latches ray_tag_in, clears mask, goes to COLLECT. core_valid is ignored in IDLE.
//  COLLECT: each cycle, every lane i with core_valid[i]=1 and mask[i]=0 latches hit/tnear and
//   sets mask[i]. Multiple lanes may strobe in the same cycle. A repeat strobe on an already-set
//   lane is ignored (first result wins). Moves to SCAN in the cycle after mask becomes all-ones.
//  SCAN: one lane per cycle, idx 0..BOX_COUNT-1; best initialised to MAX/miss on entry.
//   tnear<0 (origin inside box) is clamped to 0 before compare; compare is signed.
//   Lane wins iff hit && clamped_tnear < best (strict): ties go to the lowest index.
//   After idx=BOX_COUNT-1 goes to OUT.
//  OUT: out_valid=1, outputs stable until out_valid&&out_ready; then out_valid=0, IDLE the next cycle.
//  Latency: out_valid rises BOX_COUNT+1 cycles after the cycle in which the last lane strobe
//   is sampled. Throughput: one ray in flight.
//  start while busy=1: ignored (upstream must gate on busy). start in the same cycle as the
//   handshake completing is also ignored.
//  No hit in any lane: out_hit=0, out_index=0, out_tnear=MAX.
// CONFIGURATION
//  CLOSEST_HIT_TIMEOUT_EN defined:
//   - a counter runs in COLLECT and is cleared on entry.
//   - If the mask is not full after TIMEOUT_CYC cycles, unfilled lanes are treated as miss,
//     the FSM enters SCAN, and out_timeout=1 is carried with that result.
//   - A full mask on the same cycle the timeout fires takes precedence, so out_timeout=0.
//  Undefined: no counter; COLLECT waits indefinitely; out_timeout tied 0.
// TESTING
//  - All 4 lanes strobe together, hits tnear={0x3000,0x1000,0x2000,0x1800}, tag=0x5A ->
//    out_hit=1, idx=1, tnear=0x1000, tag=0x5A, out_valid exactly 5 cycles later.
//  - Lanes strobe on cycles 3,7,7,12; lanes 2 and 3 hit with equal tnear=0x0800 ->
//    idx=2 (tie to lowest index); out_valid at cycle 17.
//  - All lanes miss -> out_hit=0, idx=0, tnear=0x7FFF.
//  - Lane 0 hit tnear=-0x0400, lane 1 hit tnear=0x0100 -> idx=0, tnear=0x0000.
//  - out_ready held low 10 cycles, then start pulsed while busy, lane 0 strobed again ->
//    outputs stable, start and restrobe ignored, single result delivered.
//  - Reset in SCAN -> next cycle busy=0, out_valid=0; with CLOSEST_HIT_TIMEOUT_EN, lane 3 never
//    strobes -> out_timeout=1 after 64 COLLECT cycles, lane 3 reported as miss.

Source files
------------

// File: rtl/closest_hit_select.sv
// closest_hit_select: collects per-lane AABB slab results for one ray and emits the nearest hit.
// Optional collect watchdog enabled by defining CLOSEST_HIT_TIMEOUT_EN.
module closest_hit_select #(
  parameter int WIDTH = 16,
  parameter int BOX_COUNT = 4,
  parameter int TAG_W = 8,
  parameter logic [WIDTH-1:0] MAX = 16'h7FFF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [TAG_W-1:0]             ray_tag_in,
  output logic                         busy,
  input  logic [BOX_COUNT-1:0]         core_valid,
  input  logic [BOX_COUNT-1:0]         core_hit,
  input  logic [BOX_COUNT*WIDTH-1:0]   core_tnear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_hit,
  output logic [$clog2(BOX_COUNT)-1:0] out_index,
  output logic [WIDTH-1:0]             out_tnear,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_timeout
);
  localparam int IW = $clog2(BOX_COUNT);
  typedef enum logic [1:0] {IDLE, COLLECT, SCAN, OUT} state_t;
  state_t state;
  logic [BOX_COUNT-1:0] mask, hit;
  logic [WIDTH-1:0] tn [BOX_COUNT];
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] cand;
  logic win, timeout;
  assign busy = state != IDLE;
  // entry behind the origin counts as distance zero
  assign cand = tn[idx][WIDTH-1] ? '0 : tn[idx];
  assign win = hit[idx] && ($signed(cand) < $signed(out_tnear));
`ifdef CLOSEST_HIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) cnt <= (reset || state != COLLECT) ? '0 : cnt + 1'b1;
  assign timeout = cnt == LIM;
`else
  assign timeout = 1'b0;
`endif
  // out_hit/out_index/out_tnear double as the running best while scanning
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask <= '0;
      hit <= '0;
      idx <= '0;
      out_valid <= 1'b0;
      out_hit <= 1'b0;
      out_index <= '0;
      out_tnear <= MAX;
      out_tag <= '0;
      out_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          mask <= '0;
          hit <= '0;
          out_tag <= ray_tag_in;
          out_timeout <= 1'b0;
        end
        COLLECT: begin
          for (int i = 0; i < BOX_COUNT; i++)
            if (core_valid[i] && !mask[i]) begin
              mask[i] <= 1'b1;
              hit[i] <= core_hit[i];
              tn[i] <= core_tnear[i*WIDTH +: WIDTH];
            end
          if (&mask || timeout) begin
            state <= SCAN;
            idx <= '0;
            out_hit <= 1'b0;
            out_index <= '0;
            out_tnear <= MAX;
            out_timeout <= ~&mask;
          end
        end
        SCAN: begin
          if (win) begin
            out_hit <= 1'b1;
            out_index <= idx;
            out_tnear <= cand;
          end
          idx <= idx + 1'b1;
          if (idx == IW'(BOX_COUNT - 1)) begin
            state <= OUT;
            out_valid <= 1'b1;
          end
        end
        default: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_closest_hit_select.sv
// tb_closest_hit_select: scoreboard bench with a min-search reference model and random rays.
module tb_closest_hit_select;
  localparam int W = 16, N = 4, TW = 8, TO = 64;
  localparam logic [W-1:0] MAXV = 16'h7FFF;
  logic clk = 0, reset = 1, start = 0, out_ready = 0;
  logic [TW-1:0] ray_tag_in = '0;
  logic [N-1:0] core_valid = '0, core_hit = '0;
  logic [N*W-1:0] core_tnear = '0;
  logic busy, out_valid, out_hit, out_timeout;
  logic [1:0] out_index;
  logic [W-1:0] out_tnear;
  logic [TW-1:0] out_tag;
  int checks = 0, errors = 0, edges = 0;
  logic prev_valid = 0;
  typedef struct {
    logic hit;
    logic [1:0] idx;
    logic [W-1:0] tn;
    logic [TW-1:0] tag;
    logic to;
    int rise;
  } exp_t;
  exp_t q[$];

  closest_hit_select dut (
    .clk(clk), .reset(reset), .start(start), .ray_tag_in(ray_tag_in), .busy(busy),
    .core_valid(core_valid), .core_hit(core_hit), .core_tnear(core_tnear),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_index(out_index),
    .out_tnear(out_tnear), .out_tag(out_tag), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // nearest = minimum clamped distance over hit lanes; ties resolved to the first such lane
  function automatic exp_t model(logic [TW-1:0] tag, logic [N-1:0] h, logic [W-1:0] t[N],
                                 logic [N-1:0] got, int rise);
    exp_t e;
    int c[N];
    int best = 1 << 30;
    e.tag = tag; e.rise = rise; e.to = got != '1; e.hit = 0; e.idx = 0; e.tn = MAXV;
    for (int i = 0; i < N; i++) begin
      c[i] = ($signed(t[i]) < 0) ? 0 : int'(t[i]);
      if (got[i] && h[i]) begin
        e.hit = 1;
        if (c[i] < best) best = c[i];
      end
    end
    if (e.hit) begin
      e.tn = W'(best);
      for (int i = N - 1; i >= 0; i--) if (got[i] && h[i] && c[i] == best) e.idx = 2'(i);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got tag %h expected no output", out_tag);
      end else begin
        if (!prev_valid) check("latency", edges, q[0].rise);
        check("result", {out_hit, out_index, out_tnear, out_tag, out_timeout},
              {q[0].hit, q[0].idx, q[0].tn, q[0].tag, q[0].to});
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_valid = out_valid && !reset;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; start = 0; core_valid = '0; out_ready = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  // off[i]: cycle after start when lane i strobes (0 = never); dup re-strobes lane 0 with a better value;
  // poke pulses start and a lane-0 strobe while the result is held, and start again at the handshake
  task automatic ray(input logic [TW-1:0] tag, input logic [N-1:0] h, input logic [W-1:0] t[N],
                     input int off[N], input bit dup, input int stall, input bit poke);
    int mx = 0, last = 0, e0, n = 0;
    logic [N-1:0] got = '0;
    for (int i = 0; i < N; i++) begin
      if (off[i] > mx) mx = off[i];
      if (off[i] > 0) got[i] = 1;
    end
    @(posedge clk); #1;
    start = 1; ray_tag_in = tag; e0 = edges;
    core_valid = N'($urandom); core_hit = N'($urandom); core_tnear = {$urandom, $urandom};
    for (int c = 1; c <= mx; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("busy_collect", busy, 1);
      start = 0; ray_tag_in = TW'($urandom); core_valid = '0;
      core_hit = N'($urandom); core_tnear = {$urandom, $urandom};
      for (int i = 0; i < N; i++)
        if (off[i] == c) begin
          core_valid[i] = 1; core_hit[i] = h[i]; core_tnear[i*W +: W] = t[i]; last = edges;
        end
      if (dup && off[0] > 0 && c == off[0] + 1) begin
        core_valid[0] = 1; core_hit[0] = 1; core_tnear[W-1:0] = '0;
      end
    end
    q.push_back(model(tag, h, t, got, got == '1 ? last + N + 2 : e0 + 1 + TO + N));
    @(posedge clk); #1;
    start = 0; core_valid = '0;
    while (!out_valid && n < 150) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL no_output: got nothing for tag %h expected a result", tag);
      q.delete();
      do_reset();
      return;
    end
    for (int s = 0; s < stall; s++) begin
      if (poke && s == stall - 2) begin
        start = 1; core_valid = N'(1); core_hit = N'(1); core_tnear[W-1:0] = '0;
      end
      @(posedge clk); #1;
      start = 0; core_valid = '0;
    end
    out_ready = 1; start = poke;
    @(posedge clk); #1;
    out_ready = 0; start = 0;
    check("idle_after_accept", {busy, out_valid}, 0);
  endtask

  initial begin
    logic [W-1:0] t[N];
    int off[N];
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_flags", {out_hit, out_index, out_timeout}, 0);
    check("rst_tnear", out_tnear, MAXV);
    check("rst_tag", out_tag, 0);
    t = '{16'h3000, 16'h1000, 16'h2000, 16'h1800}; off = '{1, 1, 1, 1};
    ray(8'h5A, 4'hF, t, off, 0, 0, 0);
    t = '{16'h0100, 16'h0200, 16'h0800, 16'h0800}; off = '{3, 7, 7, 12};
    ray(8'h21, 4'b1100, t, off, 0, 1, 0);
    t = '{16'h0100, 16'h0200, 16'h0300, 16'h0400}; off = '{2, 1, 4, 3};
    ray(8'h77, 4'b0000, t, off, 0, 0, 0);
    t = '{16'hFC00, 16'h0100, 16'h0050, 16'h0010}; off = '{1, 2, 1, 2};
    ray(8'h4C, 4'b0011, t, off, 0, 2, 0);
    t = '{16'h2000, 16'h1000, 16'h3000, 16'h4000}; off = '{1, 3, 3, 4};
    ray(8'hC3, 4'hF, t, off, 1, 10, 1);
    @(posedge clk); #1;
    start = 1; ray_tag_in = 8'h33;
    @(posedge clk); #1;
    start = 0; core_valid = '1; core_hit = '1;
    @(posedge clk); #1;
    core_valid = '0;
    @(posedge clk); #1;
    check("busy_scan", busy, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("rst_scan_busy", busy, 0);
    check("rst_scan_valid", out_valid, 0);
    repeat (8) @(posedge clk);
    #1 check("rst_scan_quiet", {busy, out_valid}, 0);
`ifdef CLOSEST_HIT_TIMEOUT_EN
    t = '{16'h0900, 16'h0A00, 16'h0B00, 16'h0001}; off = '{1, 2, 2, 0};
    ray(8'h6D, 4'hF, t, off, 0, 1, 0);
`endif
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        int s;
        s = $urandom_range(0, 3);
        t[i] = s == 0 ? 16'h0800 : s == 1 ? (16'h8000 | 16'($urandom)) : 16'($urandom_range(0, 32766));
        off[i] = $urandom_range(1, 6);
      end
      ray(8'($urandom), 4'($urandom), t, off, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          1'($urandom_range(0, 1)));
    end
    repeat (4) @(posedge clk);
    #1 check("drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end
endmodule
